// File: rtl/icache_pkg.sv
// Shared sizes, types and address helpers for the direct-mapped instruction cache.
package icache_pkg;

   localparam int ADDR_W     = 32;
   localparam int LINE_W     = 128;
   localparam int BEAT_W     = 32;
   localparam int LINES      = 64;
   localparam int LINE_BYTES = 16;
   localparam int BEATS      = LINE_W / BEAT_W;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int IDX_W      = $clog2(LINES);
   localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
   localparam int BEAT_CNT_W = $clog2(BEATS);

   typedef logic [LINE_W-1:0]     line_t;
   typedef logic [TAG_W-1:0]      tag_t;
   typedef logic [IDX_W-1:0]      idx_t;
   typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MISS_REQ  = 2'd1,
      MISS_DATA = 2'd2
   } icache_state_e;

   typedef struct packed {
      tag_t             tag;
      idx_t             idx;
      logic [OFF_W-1:0] off;
   } addr_fields_t;

   function automatic addr_fields_t addr_split(input logic [ADDR_W-1:0] addr);
      return addr_fields_t'(addr);
   endfunction

   function automatic logic [ADDR_W-1:0] line_base(input tag_t tag, input idx_t idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/icache_fill_buf.sv
// Refill assembly buffer: counts burst beats and packs them word0-first into one line.
module icache_fill_buf
   import icache_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              beat_valid,
   input  logic [BEAT_W-1:0] beat_data,
   output line_t             line,
   output logic              last_beat
);

   beat_cnt_t beat_cnt_q, beat_cnt_d;
   line_t     fill_q, fill_d;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      fill_d     = fill_q;
      if (start) begin
         beat_cnt_d = '0;
      end else if (beat_valid) begin
         fill_d[LINE_W-1-BEAT_W*int'(beat_cnt_q) -: BEAT_W] = beat_data;
         beat_cnt_d = beat_cnt_q + beat_cnt_t'(1);
      end
   end

   // The line output already contains the beat arriving this cycle so it can be installed at once.
   assign line      = fill_d;
   assign last_beat = beat_valid & (beat_cnt_q == beat_cnt_t'(BEATS-1));

   always_ff @(posedge clock) begin
      if (reset) begin
         beat_cnt_q <= '0;
         fill_q     <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         fill_q     <= fill_d;
      end
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with 4-beat burst refill.
// Hit/miss statistics counters exist only when ICACHE_STATS_EN is defined.
//
//   state     | meaning
//   IDLE      | lookups served; a miss launches a burst
//   MISS_REQ  | mem_rd held until memory accepts
//   MISS_DATA | collecting beats; last beat installs the line
module icache
   import icache_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cache_addr,
   input  logic              cache_rd,
   output logic [LINE_W-1:0] cache_data,
   output logic              cache_waitrequest,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic [2:0]        mem_burstcount,
   input  logic              mem_waitrequest,
   input  logic [BEAT_W-1:0] mem_rddata,
   input  logic              mem_rddatavalid,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses
);

   icache_state_e     state_q, state_d;
   logic              mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              flush_pend_q, flush_pend_d;

   logic [LINES-1:0]  valid_q;
   tag_t              tag_q  [LINES];
   line_t             data_q [LINES];

   addr_fields_t      req_f, miss_f;
   logic [2*OFF_W-1:0] offsets_unused;
   logic              hit, miss_start, fill_start, beat_valid, install;
   line_t             fill_line;

   assign req_f          = addr_split(cache_addr);
   assign miss_f         = addr_split(mem_addr_q);
   assign offsets_unused = {req_f.off, miss_f.off};

   assign hit = (state_q == IDLE) & cache_rd & valid_q[req_f.idx]
              & (tag_q[req_f.idx] == req_f.tag);

   assign cache_waitrequest = cache_rd & ~hit;
   assign cache_data        = hit ? data_q[req_f.idx] : '0;
   assign mem_addr          = mem_addr_q;
   assign mem_rd            = mem_rd_q;
   assign mem_burstcount    = 3'(BEATS);

   // A miss seen together with flush waits one cycle so it looks up post-flush state.
   assign miss_start = (state_q == IDLE) & cache_rd & ~hit & ~flush;
   assign fill_start = (state_q == MISS_REQ) & ~mem_waitrequest;
   assign beat_valid = (state_q == MISS_DATA) & mem_rddatavalid;

   icache_fill_buf u_fill_buf (
      .clock      (clock),
      .reset      (reset),
      .start      (fill_start),
      .beat_valid (beat_valid),
      .beat_data  (mem_rddata),
      .line       (fill_line),
      .last_beat  (install)
   );

   always_comb begin
      state_d      = state_q;
      mem_rd_d     = mem_rd_q;
      mem_addr_d   = mem_addr_q;
      flush_pend_d = flush_pend_q;
      if ((state_q != IDLE) && flush) flush_pend_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (miss_start) begin
               state_d    = MISS_REQ;
               mem_rd_d   = 1'b1;
               mem_addr_d = line_base(req_f.tag, req_f.idx);
            end
         end
         MISS_REQ: begin
            if (fill_start) begin
               state_d  = MISS_DATA;
               mem_rd_d = 1'b0;
            end
         end
         MISS_DATA: begin
            if (install) begin
               state_d      = IDLE;
               flush_pend_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_rd_q     <= 1'b0;
         mem_addr_q   <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_rd_q     <= mem_rd_d;
         mem_addr_q   <= mem_addr_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // A flush on the install edge wins, so the refilled line lands invalid.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         valid_q <= '0;
      end else if (install) begin
         valid_q[miss_f.idx] <= ~flush_pend_q;
      end
   end

   always_ff @(posedge clock) begin
      if (install) begin
         tag_q[miss_f.idx]  <= miss_f.tag;
         data_q[miss_f.idx] <= fill_line;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] stat_hits_q, stat_hits_d;
   logic [31:0] stat_misses_q, stat_misses_d;

   always_comb begin
      stat_hits_d   = stat_hits_q + {31'd0, hit};
      stat_misses_d = stat_misses_q + {31'd0, miss_start};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_hits_q   <= '0;
         stat_misses_q <= '0;
      end else begin
         stat_hits_q   <= stat_hits_d;
         stat_misses_q <= stat_misses_d;
      end
   end

   assign stat_hits   = stat_hits_q;
   assign stat_misses = stat_misses_q;
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: vector table for cold miss/hit, hand sequences for flush, conflict, stall and reset.
module tb_icache;

   logic         clock = 1'b0;
   logic         reset;
   logic [31:0]  cache_addr;
   logic         cache_rd;
   logic [127:0] cache_data;
   logic         cache_waitrequest;
   logic         flush;
   logic [31:0]  mem_addr;
   logic         mem_rd;
   logic [2:0]   mem_burstcount;
   logic         mem_waitrequest;
   logic [31:0]  mem_rddata;
   logic         mem_rddatavalid;
   logic [31:0]  stat_hits;
   logic [31:0]  stat_misses;

`ifdef ICACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int acc_cnt  = 0;

   always #5 clock = ~clock;

   icache dut (
      .clock             (clock),
      .reset             (reset),
      .cache_addr        (cache_addr),
      .cache_rd          (cache_rd),
      .cache_data        (cache_data),
      .cache_waitrequest (cache_waitrequest),
      .flush             (flush),
      .mem_addr          (mem_addr),
      .mem_rd            (mem_rd),
      .mem_burstcount    (mem_burstcount),
      .mem_waitrequest   (mem_waitrequest),
      .mem_rddata        (mem_rddata),
      .mem_rddatavalid   (mem_rddatavalid),
      .stat_hits         (stat_hits),
      .stat_misses       (stat_misses)
   );

   // Burst accepts seen by the memory side.
   always @(posedge clock) begin
      if (!reset && mem_rd && !mem_waitrequest) acc_cnt++;
   end

   typedef struct {
      logic [31:0]  addr;
      logic         rd;
      logic         fl;
      logic         mw;
      logic         dv;
      logic [31:0]  rdata;
      logic         e_wait;
      logic [127:0] e_data;
      logic         e_mem_rd;
      logic [31:0]  e_mem_addr;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic rd, input logic fl,
                        input logic mw, input logic dv, input logic [31:0] d);
      @(negedge clock);
      cache_addr      = a;
      cache_rd        = rd;
      flush           = fl;
      mem_waitrequest = mw;
      mem_rddatavalid = dv;
      mem_rddata      = d;
      #1;
   endtask

   function automatic logic [127:0] line_of(input logic [31:0] b0);
      return {b0, b0 + 32'd1, b0 + 32'd2, b0 + 32'd3};
   endfunction

   // Full miss: request, optional memory stall, accept, four back-to-back beats, then the held read hits.
   task automatic fill_read(input logic [31:0] a, input logic [31:0] b0, input int stall);
      int acc0;
      logic [31:0] base;
      acc0 = acc_cnt;
      base = {a[31:4], 4'h0};
      drive(a, 1, 0, 0, 0, 0);
      chk("miss_wait", 128'(cache_waitrequest), 128'(1));
      chk("miss_idle_memrd", 128'(mem_rd), 128'(0));
      for (int i = 0; i < stall; i++) begin
         drive(a, 1, 0, 1, 0, 0);
         chk("stall_memrd", 128'(mem_rd), 128'(1));
         chk("stall_memaddr", 128'(mem_addr), 128'(base));
      end
      drive(a, 1, 0, 0, 0, 0);
      chk("req_memrd", 128'(mem_rd), 128'(1));
      chk("req_memaddr", 128'(mem_addr), 128'(base));
      for (int i = 0; i < 4; i++) begin
         drive(a, 1, 0, 0, 1, b0 + 32'(i));
         chk("beat_wait", 128'(cache_waitrequest), 128'(1));
         chk("beat_memrd", 128'(mem_rd), 128'(0));
      end
      drive(a, 1, 0, 0, 0, 0);
      chk("fill_wait", 128'(cache_waitrequest), 128'(0));
      chk("fill_data", cache_data, line_of(b0));
      chk("fill_accepts", 128'(acc_cnt - acc0), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] la;
      int acc0;
      la = line_of(32'hA0);
      //            addr   rd fl mw dv rdata  wait data memrd maddr
      vecs[0] = '{32'h00, 0, 0, 0, 0, 32'h0,  0, 128'h0, 0, 32'h00};
      vecs[1] = '{32'h40, 1, 0, 0, 0, 32'h0,  1, 128'h0, 0, 32'h00};
      vecs[2] = '{32'h40, 1, 0, 0, 0, 32'h0,  1, 128'h0, 1, 32'h40};
      vecs[3] = '{32'h40, 1, 0, 0, 1, 32'hA0, 1, 128'h0, 0, 32'h40};
      vecs[4] = '{32'h40, 1, 0, 0, 1, 32'hA1, 1, 128'h0, 0, 32'h40};
      vecs[5] = '{32'h40, 1, 0, 0, 1, 32'hA2, 1, 128'h0, 0, 32'h40};
      vecs[6] = '{32'h40, 1, 0, 0, 1, 32'hA3, 1, 128'h0, 0, 32'h40};
      vecs[7] = '{32'h40, 1, 0, 0, 0, 32'h0,  0, la,     0, 32'h40};
      vecs[8] = '{32'h48, 1, 0, 0, 1, 32'hDEAD, 0, la,   0, 32'h40};
      vecs[9] = '{32'h00, 0, 0, 0, 0, 32'h0,  0, 128'h0, 0, 32'h40};

      reset = 1'b1;
      cache_addr = '0; cache_rd = 0; flush = 0;
      mem_waitrequest = 0; mem_rddatavalid = 0; mem_rddata = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      acc0 = acc_cnt;
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].addr, vecs[i].rd, vecs[i].fl, vecs[i].mw, vecs[i].dv, vecs[i].rdata);
         chk($sformatf("vec%0d_wait", i), 128'(cache_waitrequest), 128'(vecs[i].e_wait));
         chk($sformatf("vec%0d_data", i), cache_data, vecs[i].e_data);
         chk($sformatf("vec%0d_memrd", i), 128'(mem_rd), 128'(vecs[i].e_mem_rd));
         chk($sformatf("vec%0d_memaddr", i), 128'(mem_addr), 128'(vecs[i].e_mem_addr));
      end
      chk("cold_accepts", 128'(acc_cnt - acc0), 128'(1));
      chk("burstcount", 128'(mem_burstcount), 128'(4));
      chk("stat_hits", 128'(stat_hits), STATS ? 128'(2) : 128'(0));
      chk("stat_misses", 128'(stat_misses), STATS ? 128'(1) : 128'(0));

      // Flush in IDLE: same-cycle lookup still hits, next read misses.
      drive(32'h40, 1, 1, 0, 0, 0);
      chk("flush_same_wait", 128'(cache_waitrequest), 128'(0));
      chk("flush_same_data", cache_data, la);
      fill_read(32'h40, 32'hB0, 0);

      // Conflict on index 4.
      fill_read(32'h440, 32'hC0, 0);
      fill_read(32'h40, 32'hD0, 0);

      // Flush during beat 2: line lands invalid, held request refetches.
      acc0 = acc_cnt;
      drive(32'h440, 1, 0, 0, 0, 0);
      chk("fp_wait", 128'(cache_waitrequest), 128'(1));
      drive(32'h440, 1, 0, 0, 0, 0);
      chk("fp_memrd", 128'(mem_rd), 128'(1));
      drive(32'h440, 1, 0, 0, 1, 32'h70);
      drive(32'h440, 1, 0, 0, 1, 32'h71);
      drive(32'h440, 1, 1, 0, 1, 32'h72);
      drive(32'h440, 1, 0, 0, 1, 32'h73);
      fill_read(32'h440, 32'h80, 0);
      chk("fp_two_bursts", 128'(acc_cnt - acc0), 128'(2));

      // Miss coincident with flush is deferred a cycle.
      drive(32'h840, 1, 1, 0, 0, 0);
      chk("defer_wait", 128'(cache_waitrequest), 128'(1));
      fill_read(32'h840, 32'h90, 0);

      // Memory backpressure for 3 cycles.
      fill_read(32'h40, 32'hE0, 3);

      // Reset mid-fill.
      drive(32'h440, 1, 0, 0, 0, 0);
      drive(32'h440, 1, 0, 0, 0, 0);
      chk("rst_req_memrd", 128'(mem_rd), 128'(1));
      drive(32'h440, 1, 0, 0, 1, 32'hF0);
      drive(32'h440, 1, 0, 0, 1, 32'hF1);
      reset = 1'b1;
      drive(32'h440, 0, 0, 0, 0, 0);
      chk("rst_memrd", 128'(mem_rd), 128'(0));
      chk("rst_memaddr", 128'(mem_addr), 128'(0));
      chk("rst_wait_idle", 128'(cache_waitrequest), 128'(0));
      chk("rst_stat_hits", 128'(stat_hits), 128'(0));
      chk("rst_stat_misses", 128'(stat_misses), 128'(0));
      reset = 1'b0;
      drive(32'h40, 0, 0, 0, 0, 0);
      drive(32'h40, 1, 0, 0, 0, 0);
      chk("rst_invalid_wait", 128'(cache_waitrequest), 128'(1));
      chk("rst_invalid_data", cache_data, 128'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
